// File: rtl/fnd_pkg.sv
// Shared types and constants for the FND scan controller and its BCD converter.
package fnd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } conv_state_t;

  localparam int NUM_DIGITS = 4;
  localparam int BCD_W      = 4;
  localparam int MAX_DISP   = 9999;
  localparam int DISP_W     = NUM_DIGITS * BCD_W;

  typedef logic [1:0] digit_idx_t;

  // Enable bit per digit: set from the most significant nonzero digit downward.
  // Digit 0 is always lit so a zero value still shows a single "0".
  function automatic logic [NUM_DIGITS-1:0] lead_mask(input logic [DISP_W-1:0] digits);
    logic seen;
    lead_mask = '0;
    seen      = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      seen         = seen | (digits[i*BCD_W +: BCD_W] != '0);
      lead_mask[i] = seen;
    end
    lead_mask[0] = 1'b1;
  endfunction

endpackage

// File: rtl/fnd_scan_ctrl_if.sv
// Value-input handshake of the FND scan controller (source = master, controller = slave).
interface fnd_scan_ctrl_if #(
  parameter int VAL_W = 14
);
  logic [VAL_W-1:0] i_value;
  logic             i_valid;
  logic             o_ready;
  logic             o_busy;

  modport master (output i_value, output i_valid, input  o_ready, input  o_busy);
  modport slave  (input  i_value, input  i_valid, output o_ready, output o_busy);
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: saturates the input to 9999, shifts VAL_W times,
// then presents the four BCD digits for one COMMIT cycle (done=1).
module bin2bcd_seq
  import fnd_pkg::*;
#(
  parameter int VAL_W = 14
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              start,
  input  logic [VAL_W-1:0]  value,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic [DISP_W-1:0] bcd
);

  localparam int CNT_W = $clog2(VAL_W + 1);

  conv_state_t       state_reg, state_next;
  logic [DISP_W-1:0] bcd_reg, bcd_next;
  logic [VAL_W-1:0]  bin_reg, bin_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              ready_reg, ready_next;
  logic              busy_reg, busy_next;
  logic [DISP_W-1:0] bcd_adj;
  logic [VAL_W-1:0]  value_sat;

  assign value_sat = (int'(value) > MAX_DISP) ? VAL_W'(MAX_DISP) : value;

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
    assign bcd_adj[gi*BCD_W +: BCD_W] = (bcd_reg[gi*BCD_W +: BCD_W] >= 4'd5)
                                      ? bcd_reg[gi*BCD_W +: BCD_W] + 4'd3
                                      : bcd_reg[gi*BCD_W +: BCD_W];
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_reg <= IDLE;
      bcd_reg   <= '0;
      bin_reg   <= '0;
      cnt_reg   <= '0;
      ready_reg <= 1'b1;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      bcd_reg   <= bcd_next;
      bin_reg   <= bin_next;
      cnt_reg   <= cnt_next;
      ready_reg <= ready_next;
      busy_reg  <= busy_next;
    end
  end

  // ready/busy are registered, so ready reappears one cycle after COMMIT.
  always_comb begin
    state_next = state_reg;
    bcd_next   = bcd_reg;
    bin_next   = bin_reg;
    cnt_next   = cnt_reg;
    ready_next = ready_reg;
    busy_next  = busy_reg;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        ready_next = !start;
        busy_next  = start;
        if (start) begin
          bin_next   = value_sat;
          bcd_next   = '0;
          cnt_next   = CNT_W'(VAL_W);
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        ready_next             = 1'b0;
        busy_next              = 1'b1;
        {bcd_next, bin_next}   = {bcd_adj, bin_reg} << 1;
        cnt_next               = cnt_reg - CNT_W'(1);
        if (cnt_reg == CNT_W'(1)) begin
          state_next = COMMIT;
        end
      end
      COMMIT: begin
        done       = 1'b1;
        ready_next = 1'b0;
        busy_next  = 1'b0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign ready = ready_reg;
  assign busy  = busy_reg;
  assign bcd   = bcd_reg;

endmodule

// File: rtl/fnd_scan_ctrl.sv
// FND display driver: converts a binary value to BCD and scans the four digits.
// Optional leading-zero blanking is enabled by defining FND_LEADING_ZERO_BLANK_EN.
module fnd_scan_ctrl
  import fnd_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int SCAN_HZ = 1000,
  parameter int VAL_W   = 14
) (
  input  logic              i_clk,
  input  logic              i_reset,
  fnd_scan_ctrl_if.slave    bus,
  output digit_idx_t        o_digitSelect,
  output logic [BCD_W-1:0]  o_bcd,
  output logic              o_en
);

  localparam int TC    = CLK_HZ / SCAN_HZ - 1;
  localparam int PRE_W = (TC < 1) ? 1 : $clog2(TC + 1);

  logic              conv_ready, conv_busy, conv_done, conv_start;
  logic [DISP_W-1:0] conv_bcd;

  logic [PRE_W-1:0]      pre_reg, pre_next;
  logic                  tick;
  logic [DISP_W-1:0]     display_reg, display_next;
  logic [NUM_DIGITS-1:0] mask_next;
  digit_idx_t            sel_reg, sel_next;
  logic [BCD_W-1:0]      bcd_reg, bcd_next;
  logic                  en_reg, en_next;
  logic [BCD_W-1:0]      disp_digit [NUM_DIGITS];

  assign conv_start = bus.i_valid && conv_ready;
  assign bus.o_ready = conv_ready;
  assign bus.o_busy  = conv_busy;

  bin2bcd_seq #(.VAL_W(VAL_W)) u_bin2bcd (
    .clk   (i_clk),
    .srst  (i_reset),
    .start (conv_start),
    .value (bus.i_value),
    .ready (conv_ready),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  assign tick     = (pre_reg == PRE_W'(TC));
  assign pre_next = tick ? '0 : pre_reg + PRE_W'(1);

  // Bypass the display register on COMMIT so a coincident tick shows the new number.
  assign display_next = conv_done ? conv_bcd : display_reg;

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    assign disp_digit[gi] = display_next[gi*BCD_W +: BCD_W];
  end

`ifdef FND_LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] mask_reg;

  assign mask_next = conv_done ? lead_mask(conv_bcd) : mask_reg;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      mask_reg <= NUM_DIGITS'(1);
    end else begin
      mask_reg <= mask_next;
    end
  end
`else
  assign mask_next = '1;
`endif

  assign sel_next = tick ? sel_reg + 2'd1 : sel_reg;
  assign bcd_next = tick ? disp_digit[sel_next] : bcd_reg;
  // Digit 0 is never blanked, so enable can come up right after reset.
  assign en_next  = tick ? mask_next[sel_next] : ((sel_reg == 2'd0) ? 1'b1 : en_reg);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pre_reg     <= '0;
      display_reg <= '0;
      sel_reg     <= '0;
      bcd_reg     <= '0;
      en_reg      <= 1'b0;
    end else begin
      pre_reg     <= pre_next;
      display_reg <= display_next;
      sel_reg     <= sel_next;
      bcd_reg     <= bcd_next;
      en_reg      <= en_next;
    end
  end

  assign o_digitSelect = sel_reg;
  assign o_bcd         = bcd_reg;
  assign o_en          = en_reg;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Scoreboard bench for fnd_scan_ctrl with CLK_HZ=8, SCAN_HZ=2 (digit step every 4 cycles).
module tb_fnd_scan_ctrl;

  localparam int CLK_HZ  = 8;
  localparam int SCAN_HZ = 2;
  localparam int VAL_W   = 14;
  localparam int BOUND   = 64;

  logic       clk = 1'b0;
  logic       srst;
  logic [1:0] sel;
  logic [3:0] bcd;
  logic       en;

  fnd_scan_ctrl_if #(.VAL_W(VAL_W)) bus ();

  fnd_scan_ctrl #(.CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ), .VAL_W(VAL_W)) dut (
    .i_clk         (clk),
    .i_reset       (srst),
    .bus           (bus),
    .o_digitSelect (sel),
    .o_bcd         (bcd),
    .o_en          (en)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] digits;
    logic [3:0]  mask;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: %0d", tag, got);
    end
  endtask

  function automatic exp_t model(input int v);
    exp_t e;
    int   s;
    int   d;
    int   top;
    s   = (v > 9999) ? 9999 : v;
    top = 0;
    for (int k = 0; k < 4; k++) begin
      d = s % 10;
      s = s / 10;
      e.digits[k*4 +: 4] = d[3:0];
      if (d != 0) top = k;
    end
    for (int k = 0; k < 4; k++) begin
`ifdef FND_LEADING_ZERO_BLANK_EN
      e.mask[k] = (k <= top);
`else
      e.mask[k] = 1'b1;
`endif
    end
    return e;
  endfunction

  // Present v, wait for the transfer edge, optionally push the expected display.
  task automatic drive(input int v, input bit push, output int waited);
    waited = 0;
    bus.i_value = VAL_W'(v);
    bus.i_valid = 1'b1;
    while (!bus.o_ready && waited < BOUND) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= BOUND) check("xfer_timeout", 0, 1);
    if (push) exp_q.push_back(model(v));
    @(negedge clk);
    bus.i_valid = 1'b0;
  endtask

  task automatic wait_done(output int ready_low, output int busy_high);
    ready_low = 0;
    busy_high = 0;
    while (!bus.o_ready && ready_low < BOUND) begin
      if (bus.o_busy) busy_high++;
      ready_low++;
      @(negedge clk);
    end
    if (ready_low >= BOUND) check("done_timeout", 0, 1);
  endtask

  // Pop one expected display and compare it over a full scan of four digits.
  task automatic check_display(input string tag);
    exp_t       e;
    logic [1:0] prev;
    int         n;
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 0, 1);
      return;
    end
    e = exp_q.pop_front();
    for (int k = 0; k < 4; k++) begin
      prev = sel;
      n    = 0;
      while (sel == prev && n < 12) begin
        @(negedge clk);
        n++;
      end
      if (n >= 12) check({tag, "_tick_timeout"}, 0, 1);
      check($sformatf("%s_bcd%0d", tag, sel), bcd, e.digits[int'(sel)*4 +: 4]);
      check($sformatf("%s_en%0d", tag, sel), en, e.mask[sel]);
    end
  endtask

  initial begin
    int   rl;
    int   bh;
    int   w;
    exp_t z;

    z           = model(0);
    srst        = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_value = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", bus.o_ready, 1);
    check("rst_busy", bus.o_busy, 0);
    check("rst_sel", sel, 0);
    check("rst_bcd", bcd, 0);
    check("rst_en", en, 0);
    srst = 1'b0;

    // 1: idle scan after reset
    for (int e = 1; e <= 20; e++) begin
      @(negedge clk);
      check($sformatf("t1_sel_e%0d", e), sel, (e / 4) % 4);
      check($sformatf("t1_bcd_e%0d", e), bcd, 0);
      check($sformatf("t1_en_e%0d", e), en, z.mask[(e / 4) % 4]);
    end

    // 2: basic conversion and latency
    drive(1234, 1'b1, w);
    wait_done(rl, bh);
    check("t2_ready_low", rl, 16);
    check("t2_busy_high", bh, 15);
    check_display("t2");

    // 3: saturation and zero
    drive(16383, 1'b1, w);
    wait_done(rl, bh);
    check_display("t3_16383");
    drive(10000, 1'b1, w);
    wait_done(rl, bh);
    check_display("t3_10000");
    drive(9999, 1'b1, w);
    wait_done(rl, bh);
    check_display("t3_9999");
    drive(0, 1'b1, w);
    wait_done(rl, bh);
    check_display("t3_0");

    // 4: valid while busy is ignored; held valid transfers once ready returns
    drive(42, 1'b1, w);
    bus.i_value = VAL_W'(5678);
    bus.i_valid = 1'b1;
    repeat (5) @(negedge clk);
    bus.i_valid = 1'b0;
    wait_done(rl, bh);
    check_display("t4_42");
    drive(100, 1'b0, w);
    drive(5678, 1'b1, w);
    check("t4_held_wait", w, 16);
    wait_done(rl, bh);
    check_display("t4_5678");

    // 5: reset during SHIFT aborts
    drive(777, 1'b0, w);
    repeat (5) @(negedge clk);
    srst = 1'b1;
    @(negedge clk);
    check("t5_ready", bus.o_ready, 1);
    check("t5_busy", bus.o_busy, 0);
    check("t5_sel", sel, 0);
    check("t5_bcd", bcd, 0);
    srst = 1'b0;
    exp_q.push_back(model(0));
    check_display("t5_0");

    // 6: blanking patterns (all digits enabled when blanking is not built in)
    drive(7, 1'b1, w);
    wait_done(rl, bh);
    check_display("t6_7");
    drive(0, 1'b1, w);
    wait_done(rl, bh);
    check_display("t6_0");
    drive(1005, 1'b1, w);
    wait_done(rl, bh);
    check_display("t6_1005");

    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
